// File: rtl/ddr_port_arbiter_pkg.sv
// ddr_port_arbiter_pkg: shared state encoding and DDR address width for the port arbiter
package ddr_port_arbiter_pkg;
  localparam int DDR_ADDR_W = 25;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;
endpackage

// File: rtl/ddr_port_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-input grant picker, round-robin against last owner or fixed s0 priority
module rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic       fixed_i,
  output logic       gnt_o,
  output logic       gnt_valid_o
);
  assign gnt_valid_o = |req_i;
  assign gnt_o = &req_i ? (!fixed_i && !last_i) : req_i[1];
endmodule

// File: rtl/ddr_port_arbiter.sv
// ddr_port_arbiter: shares one ddr_cache system port between two requesters
module ddr_port_arbiter
  import ddr_port_arbiter_pkg::*;
#(
  parameter bit FIXED_PRIORITY = 1'b0,
  parameter int ADDR_W         = DDR_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s0_valid,
  input  logic [ADDR_W-1:0] s0_addr,
  input  logic [31:0]       s0_wdata,
  input  logic [3:0]        s0_wstrb,
  output logic              s0_ready,
  output logic [31:0]       s0_rdata,
  input  logic              s1_valid,
  input  logic [ADDR_W-1:0] s1_addr,
  input  logic [31:0]       s1_wdata,
  input  logic [3:0]        s1_wstrb,
  output logic              s1_ready,
  output logic [31:0]       s1_rdata,
  output logic              m_valid,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  output logic [3:0]        m_wstrb,
  input  logic              m_ready,
  input  logic [31:0]       m_rdata,
  output logic              owner,
  output logic              busy
);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [3:0] wstrb_q, wstrb_d;
  logic owner_q, owner_d;
  logic [1:0] ready_q, ready_d;
  logic gnt, gnt_valid;

  rr_arbiter2 u_rr (
    .req_i      ({s1_valid, s0_valid}),
    .last_i     (owner_q),
    .fixed_i    (FIXED_PRIORITY),
    .gnt_o      (gnt),
    .gnt_valid_o(gnt_valid)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    owner_d  = owner_q;
    ready_d  = 2'b00;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    if (state_q == ST_IDLE && gnt_valid) begin
      state_d = ST_REQ;
      owner_d = gnt;
      addr_d  = gnt ? s1_addr : s0_addr;
      wdata_d = gnt ? s1_wdata : s0_wdata;
      wstrb_d = gnt ? s1_wstrb : s0_wstrb;
    end
    // requester valids are deliberately not consulted while a transaction is in flight
    if (state_q == ST_REQ && m_ready) begin
      state_d  = ST_RESP;
      ready_d  = owner_q ? 2'b10 : 2'b01;
      rdata0_d = owner_q ? rdata0_q : m_rdata;
      rdata1_d = owner_q ? m_rdata : rdata1_q;
    end
    if (state_q != ST_IDLE && state_q != ST_REQ) state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      owner_q  <= 1'b1;
      ready_q  <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      owner_q  <= owner_d;
      ready_q  <= ready_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign m_valid  = state_q == ST_REQ;
  assign m_addr   = addr_q;
  assign m_wdata  = wdata_q;
  assign m_wstrb  = wstrb_q;
  assign s0_ready = ready_q[0];
  assign s1_ready = ready_q[1];
  assign s0_rdata = rdata0_q;
  assign s1_rdata = rdata1_q;
  assign owner    = owner_q;
  assign busy     = state_q != ST_IDLE;
endmodule

// File: tb/tb_ddr_port_arbiter.sv
// tb_ddr_port_arbiter: directed vector table plus corner-case sequences for ddr_port_arbiter
module tb_ddr_port_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic s0_valid, s1_valid;
  logic [24:0] s0_addr, s1_addr;
  logic [31:0] s0_wdata, s1_wdata;
  logic [3:0] s0_wstrb, s1_wstrb;
  logic s0_ready, s1_ready, m_valid, owner, busy;
  logic [31:0] s0_rdata, s1_rdata, m_wdata;
  logic [24:0] m_addr;
  logic [3:0] m_wstrb;
  logic b_s0_ready, b_s1_ready, b_m_valid, b_owner, b_busy;
  logic [31:0] b_s0_rdata, b_s1_rdata, b_m_wdata;
  logic [24:0] b_m_addr;
  logic [3:0] b_m_wstrb;

  logic [31:0] cache_data;
  int lat = 4;
  logic spur = 1'b0;
  int cnt_a, cnt_b;
  logic mr_a, mr_b;
  logic [31:0] e0, e1;
  int n_vec = 0, n_fail = 0;

  ddr_port_arbiter #(.FIXED_PRIORITY(0)) dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_addr(s0_addr), .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb),
    .s0_ready(s0_ready), .s0_rdata(s0_rdata),
    .s1_valid(s1_valid), .s1_addr(s1_addr), .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb),
    .s1_ready(s1_ready), .s1_rdata(s1_rdata),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_ready(mr_a | spur), .m_rdata(cache_data), .owner(owner), .busy(busy)
  );

  ddr_port_arbiter #(.FIXED_PRIORITY(1)) dut_fixed (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_addr(s0_addr), .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb),
    .s0_ready(b_s0_ready), .s0_rdata(b_s0_rdata),
    .s1_valid(s1_valid), .s1_addr(s1_addr), .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb),
    .s1_ready(b_s1_ready), .s1_rdata(b_s1_rdata),
    .m_valid(b_m_valid), .m_addr(b_m_addr), .m_wdata(b_m_wdata), .m_wstrb(b_m_wstrb),
    .m_ready(mr_b), .m_rdata(cache_data), .owner(b_owner), .busy(b_busy)
  );

  // cache models: pulse m_ready after lat cycles of m_valid
  always @(posedge clk) begin
    if (rst) begin
      cnt_a <= 0;
      mr_a  <= 1'b0;
    end else if (m_valid && !mr_a && cnt_a == lat - 1) begin
      mr_a  <= 1'b1;
      cnt_a <= 0;
    end else begin
      mr_a  <= 1'b0;
      cnt_a <= (m_valid && !mr_a) ? cnt_a + 1 : 0;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      cnt_b <= 0;
      mr_b  <= 1'b0;
    end else if (b_m_valid && !mr_b && cnt_b == lat - 1) begin
      mr_b  <= 1'b1;
      cnt_b <= 0;
    end else begin
      mr_b  <= 1'b0;
      cnt_b <= (b_m_valid && !mr_b) ? cnt_b + 1 : 0;
    end
  end

  typedef struct {
    logic s0v, s1v;
    logic [24:0] a0, a1;
    logic [31:0] wd0, wd1;
    logic [3:0] st0, st1;
    logic [31:0] rd;
    int lat;
    logic own;
    logic [24:0] ea;
    logic [31:0] ewd;
    logic [3:0] est;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset;
    s0_valid = 1'b0;
    s1_valid = 1'b0;
    spur = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    e0 = '0;
    e1 = '0;
  endtask

  task automatic do_vec(input vec_t v);
    int seen;
    s0_valid = v.s0v; s1_valid = v.s1v;
    s0_addr = v.a0; s1_addr = v.a1;
    s0_wdata = v.wd0; s1_wdata = v.wd1;
    s0_wstrb = v.st0; s1_wstrb = v.st1;
    cache_data = v.rd;
    lat = v.lat;
    @(negedge clk);
    chk("grant_m_valid", m_valid, 1);
    chk("grant_busy", busy, 1);
    chk("grant_owner", owner, v.own);
    chk("grant_m_addr", m_addr, v.ea);
    chk("grant_m_wdata", m_wdata, v.ewd);
    chk("grant_m_wstrb", m_wstrb, v.est);
    seen = -1;
    for (int i = 0; i < v.lat + 10 && seen < 0; i++) begin
      @(negedge clk);
      if (s0_ready || s1_ready) seen = i;
    end
    chk("ready_latency", seen, v.lat);
    chk("s0_ready", s0_ready, v.own == 1'b0);
    chk("s1_ready", s1_ready, v.own == 1'b1);
    if (v.own) begin
      e1 = v.rd;
      s1_valid = 1'b0;
    end else begin
      e0 = v.rd;
      s0_valid = 1'b0;
    end
    chk("s0_rdata", s0_rdata, e0);
    chk("s1_rdata", s1_rdata, e1);
    chk("resp_m_valid", m_valid, 0);
    @(negedge clk);
    chk("ready_single_pulse", {30'b0, s1_ready, s0_ready}, 0);
    chk("idle_gap_busy", busy, 0);
  endtask

  vec_t vt[8];
  int ga[6], gb[6];
  int na, nb, extra;
  logic pa, pb, got, stable;

  initial begin
    vt[0] = '{1, 1, 25'h10, 25'h20, 32'h0, 32'h12345678, 4'h0, 4'hF, 32'hA5A50010, 4,
              0, 25'h10, 32'h0, 4'h0};
    vt[1] = '{0, 1, 25'h10, 25'h20, 32'h0, 32'h12345678, 4'h0, 4'hF, 32'h600DF00D, 2,
              1, 25'h20, 32'h12345678, 4'hF};
    vt[2] = '{1, 0, 25'h100, 25'h0, 32'h0, 32'h0, 4'h0, 4'h0, 32'hDEADBEEF, 8,
              0, 25'h100, 32'h0, 4'h0};
    vt[3] = '{1, 1, 25'h200, 25'h300, 32'h11111111, 32'h22222222, 4'h0, 4'h0, 32'h33333333, 1,
              1, 25'h300, 32'h22222222, 4'h0};
    vt[4] = '{1, 0, 25'h200, 25'h300, 32'h11111111, 32'h22222222, 4'h0, 4'h0, 32'h44444444, 3,
              0, 25'h200, 32'h11111111, 4'h0};
    vt[5] = '{0, 1, 25'h0, 25'h44, 32'h0, 32'h55AA55AA, 4'h0, 4'h3, 32'h66666666, 2,
              1, 25'h44, 32'h55AA55AA, 4'h3};
    vt[6] = '{1, 1, 25'h1FFFFFC, 25'h8, 32'h77777777, 32'h88888888, 4'h1, 4'h8, 32'h99999999, 5,
              0, 25'h1FFFFFC, 32'h77777777, 4'h1};
    vt[7] = '{0, 1, 25'h1FFFFFC, 25'h8, 32'h77777777, 32'h88888888, 4'h1, 4'h8, 32'hAAAAAAAA, 1,
              1, 25'h8, 32'h88888888, 4'h8};
    s0_addr = '0; s1_addr = '0; s0_wdata = '0; s1_wdata = '0;
    s0_wstrb = '0; s1_wstrb = '0; cache_data = '0;

    do_reset();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_m_wstrb", m_wstrb, 0);
    chk("rst_readies", {30'b0, s1_ready, s0_ready}, 0);
    chk("rst_s0_rdata", s0_rdata, 0);
    chk("rst_s1_rdata", s1_rdata, 0);
    chk("rst_owner", owner, 1);
    chk("rst_busy", busy, 0);

    for (int k = 0; k < 8; k++) do_vec(vt[k]);

    // both requesters held valid: alternate grants, or always s0 with fixed priority
    do_reset();
    for (int i = 0; i < 6; i++) begin
      ga[i] = -1;
      gb[i] = -1;
    end
    na = 0; nb = 0; pa = 0; pb = 0;
    lat = 2;
    s0_valid = 1'b1;
    s1_valid = 1'b1;
    for (int c = 0; c < 200 && (na < 6 || nb < 6); c++) begin
      @(negedge clk);
      if (m_valid && !pa && na < 6) begin
        ga[na] = int'(owner);
        na++;
      end
      if (b_m_valid && !pb && nb < 6) begin
        gb[nb] = int'(b_owner);
        nb++;
      end
      pa = m_valid;
      pb = b_m_valid;
    end
    for (int i = 0; i < 6; i++) begin
      chk("rr_grant", ga[i], i % 2);
      chk("fixed_grant", gb[i], 0);
    end

    // owner drops and changes its request two cycles into REQ
    do_reset();
    s1_addr = 25'h40; s1_wdata = 32'hCAFEF00D; s1_wstrb = 4'hC;
    cache_data = 32'h0F0F0F0F;
    lat = 6;
    s1_valid = 1'b1;
    @(negedge clk);
    chk("drop_m_valid", m_valid, 1);
    chk("drop_owner", owner, 1);
    @(negedge clk);
    s1_valid = 1'b0;
    s1_addr = 25'h55;
    s1_wdata = 32'h0;
    stable = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = s1_ready;
      if (!got) stable &= m_valid && m_addr == 25'h40 && m_wdata == 32'hCAFEF00D && m_wstrb == 4'hC;
    end
    chk("drop_stable", stable, 1);
    chk("drop_s1_ready", got, 1);
    chk("drop_s0_ready", s0_ready, 0);
    chk("drop_s1_rdata", s1_rdata, 32'h0F0F0F0F);
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      extra += int'(m_valid) + int'(s0_ready) + int'(s1_ready);
    end
    chk("drop_no_retry", extra, 0);

    // reset pulse while the cache is still working on a request
    do_reset();
    s0_addr = 25'h80; s0_wstrb = 4'h0;
    lat = 20;
    s0_valid = 1'b1;
    @(negedge clk);
    chk("rstreq_m_valid", m_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    s0_valid = 1'b0;
    chk("rstreq_m_valid_low", m_valid, 0);
    chk("rstreq_busy", busy, 0);
    chk("rstreq_owner", owner, 1);
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      extra += int'(m_valid) + int'(s0_ready) + int'(s1_ready);
    end
    chk("rstreq_quiet", extra, 0);
    do_vec('{1, 0, 25'h84, 25'h0, 32'h0, 32'h0, 4'h0, 4'h0, 32'h0BADCAFE, 3,
             0, 25'h84, 32'h0, 4'h0});

    // stray m_ready while idle
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    chk("spur_readies", {30'b0, s1_ready, s0_ready}, 0);
    chk("spur_busy", busy, 0);
    chk("spur_m_valid", m_valid, 0);
    @(negedge clk);
    chk("spur_readies_late", {30'b0, s1_ready, s0_ready}, 0);
    do_vec('{0, 1, 25'h0, 25'h1FFFFFC, 32'h0, 32'h0, 4'h0, 4'h0, 32'h13579BDF, 2,
             1, 25'h1FFFFFC, 32'h0, 4'h0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
